// File: rtl/mystery1_decoder_if.sv
//------------------------------------------------------------------------------
// mystery1_decoder_if : byte-in / record-out handshake bundle for the decoder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mystery1_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_a;
  logic [7:0] out_b;
  logic [7:0] out_c;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_c
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_a, out_b, out_c
  );
endinterface

`default_nettype wire

// File: rtl/mystery1_decoder.sv
//------------------------------------------------------------------------------
// mystery1_decoder : decodes a header/payload byte stream into (a,b,c) records.
// Optional record counter port frame_cnt when MYSTERY1_DECODER_CNT_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mystery1_decoder (
  input  logic       clk,
  input  logic       reset,
`ifdef MYSTERY1_DECODER_CNT_EN
  output logic [7:0] frame_cnt,
`endif
  mystery1_decoder_if.slave bus
);

  typedef enum logic [0:0] {
    S_HDR = 1'b0,
    S_PAY = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] mode_q,  mode_d;
  logic       valid_q, valid_d;
  logic [1:0] a_q,     a_d;
  logic [7:0] b_q,     b_d;
  logic [7:0] c_q,     c_d;

  logic in_ready;
  logic accept;
  logic out_hs;

  // The output register may be refilled in the same cycle it is drained.
  assign in_ready = ~valid_q | bus.out_ready;
  assign accept   = bus.in_valid & in_ready;
  assign out_hs   = valid_q & bus.out_ready;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;

    if (out_hs) begin
      valid_d = 1'b0;
    end

    if (accept) begin
      case (state_q)
        S_HDR: begin
          case (bus.in_data[7:6])
            2'd0: begin
              a_d     = 2'd0;
              b_d     = {5'b0, bus.in_data[5:3]};
              c_d     = {5'b0, bus.in_data[2:0]};
              valid_d = 1'b1;
            end
            2'd1: begin
              a_d     = 2'd1;
              b_d     = {5'b0, bus.in_data[2:0]};
              c_d     = {5'b0, bus.in_data[5:3]};
              valid_d = 1'b1;
            end
            default: begin
              mode_d  = bus.in_data[7:6];
              state_d = S_PAY;
            end
          endcase
        end
        S_PAY: begin
          a_d     = mode_q;
          b_d     = mode_q[0] ? 8'd0 : bus.in_data;
          c_d     = mode_q[0] ? bus.in_data : 8'd0;
          valid_d = 1'b1;
          state_d = S_HDR;
        end
        default: state_d = S_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_HDR;
      mode_q  <= 2'd0;
      valid_q <= 1'b0;
      a_q     <= 2'd0;
      b_q     <= 8'd0;
      c_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_a     = a_q;
  assign bus.out_b     = b_q;
  assign bus.out_c     = c_q;

`ifdef MYSTERY1_DECODER_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= 8'd0;
    end else if (out_hs) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mystery1_decoder.sv
//------------------------------------------------------------------------------
// tb_mystery1_decoder : directed and random stimulus against a stream-level model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mystery1_decoder;
  logic clk;
  logic reset;
`ifdef MYSTERY1_DECODER_CNT_EN
  logic [7:0] frame_cnt;
`endif

  mystery1_decoder_if bus ();

  mystery1_decoder dut (
    .clk       (clk),
    .reset     (reset),
`ifdef MYSTERY1_DECODER_CNT_EN
    .frame_cnt (frame_cnt),
`endif
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: records decoded from the accepted byte stream, waiting downstream.
  typedef struct packed { logic [1:0] a; logic [7:0] b; logic [7:0] c; } rec_t;
  rec_t  pend_q[$];
  rec_t  last_rec;
  int    pay_mode;   // -1 when the next byte is a header
  int    m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    pend_q.delete();
    last_rec = '0;
    pay_mode = -1;
    m_cnt    = 0;
  endtask

  function automatic rec_t decode_hdr(input logic [7:0] d);
    rec_t r;
    r.a = d[7:6];
    if (d[7:6] == 2'd0) begin
      r.b = {5'b0, d[5:3]}; r.c = {5'b0, d[2:0]};
    end else begin
      r.b = {5'b0, d[2:0]}; r.c = {5'b0, d[5:3]};
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ":out_valid"}, 32'(bus.out_valid), 32'(pend_q.size() > 0));
    chk({tag, ":out_a"}, 32'(bus.out_a), 32'(last_rec.a));
    chk({tag, ":out_b"}, 32'(bus.out_b), 32'(last_rec.b));
    chk({tag, ":out_c"}, 32'(bus.out_c), 32'(last_rec.c));
`ifdef MYSTERY1_DECODER_CNT_EN
    chk({tag, ":frame_cnt"}, 32'(frame_cnt), 32'(m_cnt % 256));
`endif
  endtask

  // One clock cycle: present inputs, check in_ready, clock, update model, check.
  task automatic step(input logic [7:0] d, input logic v, input logic r, input string tag);
    logic exp_ready, acc;
    rec_t rec;
    bus.in_data   = d;
    bus.in_valid  = v;
    bus.out_ready = r;
    #2;
    exp_ready = (pend_q.size() == 0) || r;
    chk({tag, ":in_ready"}, 32'(bus.in_ready), 32'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (pend_q.size() > 0 && r) begin
      void'(pend_q.pop_front());
      m_cnt++;
    end
    if (acc) begin
      if (pay_mode < 0) begin
        if (d[7:6] < 2) begin
          rec = decode_hdr(d);
          pend_q.push_back(rec);
          last_rec = rec;
        end else begin
          pay_mode = int'(d[7:6]);
        end
      end else begin
        rec.a = 2'(pay_mode);
        rec.b = (pay_mode == 2) ? d : 8'd0;
        rec.c = (pay_mode == 3) ? d : 8'd0;
        pend_q.push_back(rec);
        last_rec = rec;
        pay_mode = -1;
      end
    end
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h5D;
    bus.out_ready = 1'b0;
    #1;
    chk("reset:in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    model_clear();
    check_outputs("reset");
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'h00;
    bus.out_ready = 1'b0;
    model_clear();
    #2;
    do_reset();

    // Mode 0 then mode 1 headers, and back-to-back headers
    step(8'h1D, 1, 1, "m0");
    chk("m0:b_abs", 32'(bus.out_b), 32'h03);
    chk("m0:c_abs", 32'(bus.out_c), 32'h05);
    step(8'h5D, 1, 1, "m1");
    chk("m1:b_abs", 32'(bus.out_b), 32'h05);
    step(8'h1D, 1, 1, "b2b0");
    step(8'h5D, 1, 1, "b2b1");
    chk("b2b1:valid_abs", 32'(bus.out_valid), 32'd1);
    step(8'h00, 0, 1, "drain");

    // Mode 2 and mode 3 header/payload pairs, with an idle gap in PAY
    step(8'hBF, 1, 1, "m2h");
    step(8'h55, 0, 1, "m2idle");
    step(8'hA7, 1, 1, "m2p");
    chk("m2p:b_abs", 32'(bus.out_b), 32'hA7);
    step(8'hC0, 1, 1, "m3h");
    step(8'h3C, 1, 1, "m3p");
    chk("m3p:c_abs", 32'(bus.out_c), 32'h3C);
    step(8'h00, 0, 1, "drain2");

    // Backpressure hold
    step(8'h5D, 1, 1, "hold0");
    for (int i = 0; i < 5; i++) step(8'(i * 37 + 1), 1, 0, "hold");
    step(8'h00, 0, 1, "release");

    // Reset in PAY discards the partial record
    step(8'h80, 1, 1, "payrst");
    do_reset();
    step(8'h1D, 1, 1, "afterrst");
    chk("afterrst:a_abs", 32'(bus.out_a), 32'd0);
    chk("afterrst:b_abs", 32'(bus.out_b), 32'h03);

    // Randomised traffic
    for (int i = 0; i < 400; i++)
      step(8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), "rand");

`ifdef MYSTERY1_DECODER_CNT_EN
    do_reset();
    for (int i = 0; i < 257; i++) step(8'h1D, 1, 1, "cnt");
    step(8'h00, 0, 1, "cntdrain");
    chk("cnt:wrap", 32'(frame_cnt), 32'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
